mile_counter: RTL

Trip-distance front end for the taxi meter: turns the raw wheel-sensor pulse train into the 13-bit kilometre count that the fare calculator consumes on its `Mile` input. It synchronizes and edge-detects the wheel pulse, runs a hire-state machine (idle / running / holding), and accumulates whole kilometres. It also flags when the cab is stopped during a hire. It sits between the sensor pad and the fare block, in the same `CLK` domain.

---
 rtl/mile_counter_if.sv | 29 ++
 rtl/mile_counter.sv | 116 +++++++++++
 2 files changed

// File: rtl/mile_counter_if.sv
// Bus between the taxi-meter controls / wheel sensor and the trip-distance
// front end.
//   START, STOP : hire controls (synchronous levels)
//   PULSE       : raw wheel sensor (asynchronous)
//   Mile        : whole kilometres of the current or last hire
//   Mile_tick   : one-cycle strobe on each Mile increment
//   Running     : hire in progress
//   Waiting     : cab stationary during a hire
//   Sat         : Mile has saturated at its maximum
interface mile_counter_if;
  logic        START;
  logic        STOP;
  logic        PULSE;
  logic [12:0] Mile;
  logic        Mile_tick;
  logic        Running;
  logic        Waiting;
  logic        Sat;

  modport master (
    output START, STOP, PULSE,
    input  Mile, Mile_tick, Running, Waiting, Sat
  );

  modport slave (
    input  START, STOP, PULSE,
    output Mile, Mile_tick, Running, Waiting, Sat
  );
endinterface

// File: rtl/mile_counter.sv
// Trip-distance front end: synchronises and edge-detects the wheel pulse,
// runs the hire state machine (IDLE / RUN / HOLD) and accumulates whole
// kilometres for the fare block.
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : mile_counter_if.slave (controls in, distance/status out)
// Parameters:
//   PPK         : wheel pulses per kilometre (2..1023)
//   WAIT_CYCLES : idle RUN cycles before Waiting asserts (2..65535)
module mile_counter #(
  parameter int PPK         = 10,
  parameter int WAIT_CYCLES = 50
) (
  input  logic          CLK,
  input  logic          RST_N,
  mile_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [9:0]  PC_LAST  = 10'(PPK - 1);
  localparam logic [15:0] WAIT_MAX = 16'(WAIT_CYCLES);
  localparam logic [12:0] MILE_MAX = '1;

  state_t      state;
  logic        s1, s2, s3;
  logic [9:0]  pcnt;
  logic [15:0] wcnt;
  logic [12:0] mile_q;
  logic        tick_q;
  logic        running_q;
  logic        waiting_q;
  logic        sat_q;
  logic        pulse_edge;

  // Rising edge of the synchronised wheel pulse.
  assign pulse_edge = s2 & ~s3;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      pcnt      <= '0;
      wcnt      <= '0;
      mile_q    <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      waiting_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      // Synchroniser runs in every state so a level held across a state
      // change never looks like a fresh edge.
      s1     <= bus.PULSE;
      s2     <= s1;
      s3     <= s2;
      tick_q <= 1'b0;

      case (state)
        IDLE, HOLD: begin
          wcnt      <= '0;
          waiting_q <= 1'b0;
          running_q <= 1'b0;
          if (bus.START) begin
            state     <= RUN;
            running_q <= 1'b1;
            mile_q    <= '0;
            pcnt      <= '0;
            sat_q     <= 1'b0;
          end
        end

        RUN: begin
          if (bus.STOP) begin
            // STOP wins over a coincident edge; that edge is dropped.
            state     <= HOLD;
            running_q <= 1'b0;
            waiting_q <= 1'b0;
            wcnt      <= '0;
          end else if (pulse_edge) begin
            wcnt      <= '0;
            waiting_q <= 1'b0;
            if (pcnt == PC_LAST) begin
              pcnt <= '0;
              if (mile_q == MILE_MAX) begin
                sat_q <= 1'b1;
              end else begin
                mile_q <= mile_q + 13'd1;
                tick_q <= 1'b1;
              end
            end else begin
              pcnt <= pcnt + 10'd1;
            end
          end else if (wcnt != WAIT_MAX) begin
            // Compare against the next count so Waiting rises in the same
            // cycle the counter reaches WAIT_CYCLES.
            wcnt      <= wcnt + 16'd1;
            waiting_q <= ((wcnt + 16'd1) == WAIT_MAX);
          end else begin
            waiting_q <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Mile      = mile_q;
  assign bus.Mile_tick = tick_q;
  assign bus.Running   = running_q;
  assign bus.Waiting   = waiting_q;
  assign bus.Sat       = sat_q;

endmodule
